rom_arbiter: RTL

- Shares the single 256x16 synchronous `rom` component between two requesters.
- Requester 0 is instruction fetch; requester 1 is constant/data load.
- Round-robin arbitration, one outstanding ROM read at a time, per-requester response pulse.
- Sits between the CPU front end / load unit and the `rom` instance; owns the ROM address bus.

---
 rtl/rom_arb_pkg.sv | 16 +
 rtl/rr_arbiter_2.sv | 20 ++
 rtl/rom_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-requester ROM arbiter.
// Requester 0 is instruction fetch, requester 1 is constant/data load.
package rom_arb_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 16;

  localparam int REQ_FETCH = 0;
  localparam int REQ_LOAD  = 1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin pick: on a tie, the requester that
// did not win last time is selected.
module rr_arbiter_2 (
  input  logic req_0,
  input  logic req_1,
  input  logic last,
  output logic sel,
  output logic any
);

  always_comb begin
    any = req_0 | req_1;
    if (req_0 && req_1) begin
      sel = ~last;
    end else begin
      sel = req_1;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous ROM between fetch and load requesters, one read
// in flight at a time, with a per-requester registered response pulse.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_0,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  output logic                  gnt_0,
  output logic                  rvalid_0,
  output logic [DATA_WIDTH-1:0] rdata_0,
  input  logic                  req_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  output logic                  gnt_1,
  output logic                  rvalid_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  busy
);

  localparam int CNT_W = $clog2(ROM_LATENCY + 1);

  state_t          state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic            owner, owner_next;
  logic            last, last_next;
  logic [ADDR_WIDTH-1:0] address_next;
  logic [DATA_WIDTH-1:0] rdata_0_next, rdata_1_next;
  logic            rvalid_0_next, rvalid_1_next;
  logic            sel, any;

  rr_arbiter_2 u_pick (
    .req_0 (req_0),
    .req_1 (req_1),
    .last  (last),
    .sel   (sel),
    .any   (any)
  );

  // Grants are only offered while idle and never while reset is asserted.
  assign gnt_0 = !reset && (state == IDLE) && any && (sel == 1'(REQ_FETCH));
  assign gnt_1 = !reset && (state == IDLE) && any && (sel == 1'(REQ_LOAD));
  assign busy  = (state == WAIT);

  always_comb begin
    state_next    = state;
    count_next    = count;
    owner_next    = owner;
    last_next     = last;
    address_next  = rom_address;
    rdata_0_next  = rdata_0;
    rdata_1_next  = rdata_1;
    rvalid_0_next = 1'b0;
    rvalid_1_next = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          address_next = sel ? addr_1 : addr_0;
          owner_next   = sel;
          last_next    = sel;
          count_next   = CNT_W'(ROM_LATENCY);
          state_next   = WAIT;
        end
      end
      WAIT: begin
        if (count != '0) begin
          count_next = count - CNT_W'(1);
        end else begin
          // Response demux: only the owner's data register is updated.
          if (owner == 1'(REQ_LOAD)) begin
            rdata_1_next  = rom_data;
            rvalid_1_next = 1'b1;
          end else begin
            rdata_0_next  = rom_data;
            rvalid_0_next = 1'b1;
          end
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      owner       <= 1'b0;
      last        <= 1'b1;
      rom_address <= '0;
      rdata_0     <= '0;
      rdata_1     <= '0;
      rvalid_0    <= 1'b0;
      rvalid_1    <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      owner       <= owner_next;
      last        <= last_next;
      rom_address <= address_next;
      rdata_0     <= rdata_0_next;
      rdata_1     <= rdata_1_next;
      rvalid_0    <= rvalid_0_next;
      rvalid_1    <= rvalid_1_next;
    end
  end

endmodule
